gc_ram_scheduler: RTL and testbench
===================================

// Module: gc_ram_scheduler
// PURPOSE
//   Round-robin scheduler sharing the gamecube emulator's single 32-byte I2C-side SRAM
//   read port among the four gc_controller cores. It takes per-port request/address pairs
//   and drives the shared RAM address. After a programmable read latency it raises that
//   port's ack and holds it, with the address stable, until the port drops its request.
//   The RAM data bus is broadcast to all ports and is not routed through this block.
// PARAMETERS
//   READ_LATENCY  1  clocks from ram_addr change to ram_data valid; legal range 1..15
// PORTS
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-low reset (0 = in reset)
//   req        in   4   per-port request, level; bit n = port n
//   port_addr  in   12  per-port byte address; port n uses bits [3n+2:3n]
//   ram_addr   out  5   shared RAM address = {grant, latched port_addr of granted port}
//   ack        out  4   per-port ack, one-hot or zero; means ram_data is valid for that port
//   grant      out  2   index of the port currently being served
//   busy       out  1   1 from the grant cycle to the ack-release cycle, inclusive
// BEHAVIOUR
//   Reset (reset=0, asynchronous): ram_addr=0, ack=0, grant=0, busy=0, state=S_IDLE,
//     last=3 (the first arbitration after reset favours port 0), latency counter=0.
//   State register: S_IDLE, S_WAIT, S_ACK.
//   S_IDLE: if req!=0, pick the first set bit scanning last+1, last+2, ... mod 4.
//     At that edge: grant<=g, ram_addr<={g, port_addr[g]}, busy<=1,
//     cnt<=READ_LATENCY-1, then go to S_WAIT. The address is latched, so later
//     port_addr changes are ignored until the next grant. If req==0, stay in S_IDLE.
//   S_WAIT: if req[g]==0 (abort), busy<=0, last<=g, go to S_IDLE with no ack.
//     Else if cnt==0, ack[g]<=1 and go to S_ACK. Else cnt<=cnt-1.
//     ack therefore rises exactly READ_LATENCY edges after the grant edge.
//   S_ACK: while req[g]==1, hold ack[g], ram_addr and grant. When req[g]==0,
//     ack<=0, busy<=0, last<=g, go to S_IDLE.
//   Minimum cycle per transaction: 1 grant + READ_LATENCY + 1 release edge. The
//     earliest next grant is the edge after release; there are no back-to-back grants
//     without passing through S_IDLE.
//   Requests from non-granted ports are ignored while busy. They must stay asserted
//     to win a later arbitration; there is no queueing or latching of requests.
//   Fairness: after port g is served or aborts, g becomes lowest priority. A port that
//     re-requests continuously can never starve the others. Worst-case wait is
//     3 full transactions.
//   Simultaneous events: req[g] falling on the same edge cnt reaches 0 is an abort,
//     so no ack is issued. The abort check takes priority over the ack.
//   Reset asserted mid-transaction clears ack immediately (async) and restores the
//     reset values. Requesters must tolerate the lost ack by re-requesting.
//   Invariants: ack is never multi-hot; ack[n]=1 implies grant==n and busy==1;
//     ram_addr[4:3]==grant whenever busy==1.
// TESTING
//   1) LAT=1, port2 req, addr=5 -> next edge ram_addr=0x15, grant=2, busy=1; ack=4'b0100
//      one edge later. Drop req -> ack=0, busy=0 on the next edge.
//   2) LAT=1, req=4'b1111 held from reset, each port drops req 1 clk after its ack,
//      then re-raises -> grant order 0,1,2,3,0,... with ram_addr[4:3] matching.
//   3) Port0 re-requests immediately after each release, port3 requests once ->
//      port3 is granted before port0's second grant.
//   4) LAT=3, port1 req, drop req 1 edge after grant -> ack never rises; next arbitration
//      treats last=1 (port2 wins over port1 if both request).
//   5) Port3 in S_ACK, change port_addr[11:9] from 2 to 6 -> ram_addr stays 0x1A until
//      release.
//   6) Assert reset (0) while ack=4'b1000 -> ack, busy, ram_addr go to 0 without a clock.
//      After release, req=4'b1001 -> port0 is granted first.

Source files
------------

// File: rtl/gc_ram_scheduler.sv
// gc_ram_scheduler: round-robin arbiter for the shared 32-byte SRAM read port.
// Grants one of four controller ports, then acks after READ_LATENCY clocks.
module gc_ram_scheduler #(
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [11:0] port_addr,
   output logic [4:0]  ram_addr,
   output logic [3:0]  ack,
   output logic [1:0]  grant,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

   state_t     state, state_nx;
   logic [1:0] last, last_nx;
   logic [1:0] grant_nx, pick;
   logic [3:0] cnt, cnt_nx;
   logic [3:0] ack_nx;
   logic [4:0] addr_nx;
   logic       busy_nx, found;
   logic [2:0] pick_addr;

   // first requesting port after the last one served, wrapping mod 4
   always_comb begin
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!found && req[last + 2'(i)]) begin
            pick  = last + 2'(i);
            found = 1'b1;
         end
      end
   end

   // byte address field of the candidate port
   always_comb begin
      pick_addr = port_addr[2:0];
      unique case (pick)
         2'd0: pick_addr = port_addr[2:0];
         2'd1: pick_addr = port_addr[5:3];
         2'd2: pick_addr = port_addr[8:6];
         2'd3: pick_addr = port_addr[11:9];
         default: pick_addr = port_addr[2:0];
      endcase
   end

   // next-state and registered-output logic; abort wins over ack
   always_comb begin
      state_nx = state;
      last_nx  = last;
      cnt_nx   = cnt;
      grant_nx = grant;
      addr_nx  = ram_addr;
      ack_nx   = ack;
      busy_nx  = busy;
      unique case (state)
         S_IDLE: begin
            if (found) begin
               grant_nx = pick;
               addr_nx  = {pick, pick_addr};
               busy_nx  = 1'b1;
               cnt_nx   = CNT_INIT;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!req[grant]) begin
               busy_nx  = 1'b0;
               last_nx  = grant;
               state_nx = S_IDLE;
            end else if (cnt == 4'd0) begin
               ack_nx   = 4'b0001 << grant;
               state_nx = S_ACK;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         S_ACK: begin
            if (!req[grant]) begin
               ack_nx   = 4'b0000;
               busy_nx  = 1'b0;
               last_nx  = grant;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // state and output registers; reset favours port 0 first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         last     <= 2'd3;
         cnt      <= 4'd0;
         grant    <= 2'd0;
         ram_addr <= 5'd0;
         ack      <= 4'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         last     <= last_nx;
         cnt      <= cnt_nx;
         grant    <= grant_nx;
         ram_addr <= addr_nx;
         ack      <= ack_nx;
         busy     <= busy_nx;
      end
   end

endmodule

// File: tb/tb_gc_ram_scheduler.sv
// tb_gc_ram_scheduler: scoreboard bench for gc_ram_scheduler.
// Expected acks are queued by stimulus and popped by a negedge monitor.
module tb_gc_ram_scheduler;

   typedef struct {
      int         port;
      logic [4:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req1 = 4'd0;
   logic [11:0] pa1 = 12'd0;
   logic [4:0]  ram_addr1;
   logic [3:0]  ack1;
   logic [1:0]  grant1;
   logic        busy1;
   logic [3:0]  req3 = 4'd0;
   logic [11:0] pa3 = 12'd0;
   logic [4:0]  ram_addr3;
   logic [3:0]  ack3;
   logic [1:0]  grant3;
   logic        busy3;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   logic [3:0] prev_ack = 4'd0;

   gc_ram_scheduler #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req(req1), .port_addr(pa1),
      .ram_addr(ram_addr1), .ack(ack1), .grant(grant1), .busy(busy1)
   );

   gc_ram_scheduler #(.READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req(req3), .port_addr(pa3),
      .ram_addr(ram_addr3), .ack(ack3), .grant(grant3), .busy(busy3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int p, input logic [4:0] a);
      exp_t e;
      e.port = p;
      e.addr = a;
      q.push_back(e);
   endtask

   // monitor: every rising ack on dut1 must match the next queued entry
   always @(negedge clk) begin
      if (ack1 != 4'd0 && prev_ack == 4'd0) begin
         if (q.size() == 0) begin
            chk("unexpected_ack", {28'd0, ack1}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("mon_ack", {28'd0, ack1}, 32'(4'b0001 << e.port));
            chk("mon_grant", {30'd0, grant1}, 32'(e.port));
            chk("mon_addr", {27'd0, ram_addr1}, {27'd0, e.addr});
            chk("mon_busy", {31'd0, busy1}, 32'd1);
         end
      end
      prev_ack <= ack1;
   end

   // wait for ack of port p, release it, optionally re-request
   task automatic finish_one(input int p, input bit rereq);
      int n;
      n = 0;
      while (ack1 == 4'd0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ack", {28'd0, ack1}, 32'(4'b0001 << p));
      req1[p] = 1'b0;
      @(negedge clk);
      chk("rel_ack", {28'd0, ack1}, 32'd0);
      chk("rel_busy", {31'd0, busy1}, 32'd0);
      if (rereq) req1[p] = 1'b1;
   endtask

   initial begin
      // reset values
      req1 = 4'b1111;
      pa1 = {3'd4, 3'd3, 3'd2, 3'd1};
      #12;
      chk("rst_addr", {27'd0, ram_addr1}, 32'd0);
      chk("rst_ack", {28'd0, ack1}, 32'd0);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_grant", {30'd0, grant1}, 32'd0);
      chk("rst_busy3", {31'd0, busy3}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // round robin with all four requesting
      for (int k = 0; k < 5; k++) push(k % 4, 5'((k % 4) * 8 + (k % 4) + 1));
      for (int k = 0; k < 5; k++) finish_one(k % 4, 1'b1);
      req1 = 4'd0;
      @(negedge clk);

      // port3 requests during port0 service, port0 re-requests at once
      push(0, 5'h01);
      push(3, 5'h1C);
      push(0, 5'h01);
      req1 = 4'b0001;
      @(negedge clk);
      req1[3] = 1'b1;
      finish_one(0, 1'b1);
      finish_one(3, 1'b0);
      finish_one(0, 1'b0);
      @(negedge clk);

      // single port2 transaction, exact timing
      pa1[8:6] = 3'd5;
      push(2, 5'h15);
      req1 = 4'b0100;
      @(negedge clk);
      chk("t1_addr", {27'd0, ram_addr1}, 32'h15);
      chk("t1_grant", {30'd0, grant1}, 32'd2);
      chk("t1_busy", {31'd0, busy1}, 32'd1);
      chk("t1_noack", {28'd0, ack1}, 32'd0);
      @(negedge clk);
      chk("t1_ack", {28'd0, ack1}, 32'b0100);
      req1 = 4'd0;
      @(negedge clk);
      chk("t1_rel_ack", {28'd0, ack1}, 32'd0);
      chk("t1_rel_busy", {31'd0, busy1}, 32'd0);

      // LAT=3 abort one edge after grant
      req3 = 4'b0010;
      @(negedge clk);
      chk("t4_grant", {30'd0, grant3}, 32'd1);
      chk("t4_busy", {31'd0, busy3}, 32'd1);
      req3 = 4'd0;
      @(negedge clk);
      chk("t4_abort_busy", {31'd0, busy3}, 32'd0);
      chk("t4_abort_ack", {28'd0, ack3}, 32'd0);
      @(negedge clk);
      chk("t4_noack", {28'd0, ack3}, 32'd0);
      req3 = 4'b0110;
      @(negedge clk);
      chk("t4_rr_grant", {30'd0, grant3}, 32'd2);
      @(negedge clk);
      chk("t4_lat1", {28'd0, ack3}, 32'd0);
      @(negedge clk);
      chk("t4_lat2", {28'd0, ack3}, 32'd0);
      @(negedge clk);
      chk("t4_lat3", {28'd0, ack3}, 32'b0100);
      req3 = 4'd0;
      @(negedge clk);
      chk("t4_rel_busy", {31'd0, busy3}, 32'd0);

      // LAT=3 drop on the edge the count expires -> no ack
      req3 = 4'b0001;
      @(negedge clk);
      chk("t4b_grant", {30'd0, grant3}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      req3 = 4'd0;
      @(negedge clk);
      chk("t4b_ack", {28'd0, ack3}, 32'd0);
      chk("t4b_busy", {31'd0, busy3}, 32'd0);

      // address latched while in ack
      pa1[11:9] = 3'd2;
      push(3, 5'h1A);
      req1 = 4'b1000;
      @(negedge clk);
      @(negedge clk);
      pa1[11:9] = 3'd6;
      @(negedge clk);
      chk("t5_addr", {27'd0, ram_addr1}, 32'h1A);
      chk("t5_ack", {28'd0, ack1}, 32'b1000);
      @(negedge clk);
      chk("t5_addr2", {27'd0, ram_addr1}, 32'h1A);

      // asynchronous reset mid-ack
      #2 reset = 1'b0;
      #1;
      chk("t6_ack", {28'd0, ack1}, 32'd0);
      chk("t6_busy", {31'd0, busy1}, 32'd0);
      chk("t6_addr", {27'd0, ram_addr1}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      push(0, 5'h01);
      push(3, 5'h1E);
      req1 = 4'b1001;
      finish_one(0, 1'b0);
      finish_one(3, 1'b0);
      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
